// File: rtl/pipe_decode.sv
// RV32I decode stage: registers one decoded instruction per pipeline step; one cycle latency, holds while stepPipe=0.
// Optional load-use interlock (define PIPE_DECODE_HAZARD_EN) replays the dependent instruction after a bubble.
module pipe_decode #(
  parameter logic [31:0] BUBBLE_INSTRUCTION = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stepPipe,
  input  logic        pipeStall,
  input  logic [31:0] instruction,
  input  logic [31:0] programCounter,
  output logic        hazardStall,
  output logic        decodeValid,
  output logic [31:0] decodeProgramCounter,
  output logic [4:0]  rs1Address,
  output logic [4:0]  rs2Address,
  output logic [4:0]  rdAddress,
  output logic [31:0] immediate,
  output logic [2:0]  funct3,
  output logic        funct7Bit5,
  output logic        isLui,
  output logic        isAuipc,
  output logic        isJal,
  output logic        isJalr,
  output logic        isBranch,
  output logic        isLoad,
  output logic        isStore,
  output logic        isAluImm,
  output logic        isAluReg,
  output logic        isSystem,
  output logic        invalidInstruction
);

  typedef struct packed {
    logic        valid;
    logic        invalid;
    logic        is_lui;
    logic        is_auipc;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_alu_imm;
    logic        is_alu_reg;
    logic        is_system;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] pc;
  } slot_t;

  logic [31:0] src_instr;
  logic [31:0] src_pc;
  logic        live_bubble;
  logic        hazard;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  slot_t       dec;
  slot_t       slot_d;
  slot_t       slot_q;

  assign live_bubble = pipeStall || (instruction == BUBBLE_INSTRUCTION);

`ifdef PIPE_DECODE_HAZARD_EN
  typedef enum logic {NORMAL, REPLAY} state_t;
  state_t      state_q, state_d;
  logic [31:0] replay_instr_q;
  logic [31:0] replay_pc_q;
  logic        load_busy;

  assign src_instr = (state_q == REPLAY) ? replay_instr_q : instruction;
  assign src_pc    = (state_q == REPLAY) ? replay_pc_q    : programCounter;

  // rd!=0 is required, so the zeroed rs fields of formats without sources never match.
  assign load_busy = slot_q.valid && slot_q.is_load && (slot_q.rd != 5'd0);
  assign hazard    = (state_q == NORMAL) && load_busy && !live_bubble &&
                     ((dec.rs1 == slot_q.rd) || (dec.rs2 == slot_q.rd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= NORMAL;
      replay_instr_q <= BUBBLE_INSTRUCTION;
      replay_pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (stepPipe && hazard) begin
        replay_instr_q <= instruction;
        replay_pc_q    <= programCounter;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = '0;
    if (state_q == REPLAY) begin
      if (stepPipe) state_d = NORMAL;
      if (replay_instr_q != BUBBLE_INSTRUCTION) slot_d = dec;
    end else begin
      if (stepPipe && hazard) state_d = REPLAY;
      if (!hazard && !live_bubble) slot_d = dec;
    end
  end
`else
  assign src_instr = instruction;
  assign src_pc    = programCounter;
  assign hazard    = 1'b0;

  always_comb begin
    slot_d = '0;
    if (!live_bubble) slot_d = dec;
  end
`endif

  assign imm_i = {{20{src_instr[31]}}, src_instr[31:20]};
  assign imm_s = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
  assign imm_b = {{19{src_instr[31]}}, src_instr[31], src_instr[7], src_instr[30:25], src_instr[11:8], 1'b0};
  assign imm_u = {src_instr[31:12], 12'd0};
  assign imm_j = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12], src_instr[20], src_instr[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.pc    = src_pc;
    dec.f3    = src_instr[14:12];
    dec.f7b5  = src_instr[30];
    if (src_instr[1:0] != 2'b11) begin
      dec.invalid = 1'b1;
    end else begin
      case (src_instr[6:0])
        7'h37: begin dec.is_lui = 1'b1; dec.rd = src_instr[11:7]; dec.imm = imm_u; end
        7'h17: begin dec.is_auipc = 1'b1; dec.rd = src_instr[11:7]; dec.imm = imm_u; end
        7'h6F: begin dec.is_jal = 1'b1; dec.rd = src_instr[11:7]; dec.imm = imm_j; end
        7'h67: begin
          dec.is_jalr = 1'b1; dec.rd = src_instr[11:7]; dec.rs1 = src_instr[19:15]; dec.imm = imm_i;
        end
        7'h63: begin
          dec.is_branch = 1'b1; dec.rs1 = src_instr[19:15]; dec.rs2 = src_instr[24:20]; dec.imm = imm_b;
        end
        7'h03: begin
          dec.is_load = 1'b1; dec.rd = src_instr[11:7]; dec.rs1 = src_instr[19:15]; dec.imm = imm_i;
        end
        7'h23: begin
          dec.is_store = 1'b1; dec.rs1 = src_instr[19:15]; dec.rs2 = src_instr[24:20]; dec.imm = imm_s;
        end
        7'h13: begin
          dec.is_alu_imm = 1'b1; dec.rd = src_instr[11:7]; dec.rs1 = src_instr[19:15]; dec.imm = imm_i;
        end
        7'h33: begin
          dec.is_alu_reg = 1'b1; dec.rd = src_instr[11:7]; dec.rs1 = src_instr[19:15]; dec.rs2 = src_instr[24:20];
        end
        7'h73: begin
          dec.is_system = 1'b1; dec.rd = src_instr[11:7]; dec.rs1 = src_instr[19:15]; dec.imm = imm_i;
        end
        default: dec.invalid = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slot_q <= '0;
    else if (stepPipe) slot_q <= slot_d;
  end

  assign hazardStall          = hazard;
  assign decodeValid          = slot_q.valid;
  assign invalidInstruction   = slot_q.invalid;
  assign decodeProgramCounter = slot_q.pc;
  assign rs1Address           = slot_q.rs1;
  assign rs2Address           = slot_q.rs2;
  assign rdAddress            = slot_q.rd;
  assign immediate            = slot_q.imm;
  assign funct3               = slot_q.f3;
  assign funct7Bit5           = slot_q.f7b5;
  assign isLui                = slot_q.is_lui;
  assign isAuipc              = slot_q.is_auipc;
  assign isJal                = slot_q.is_jal;
  assign isJalr               = slot_q.is_jalr;
  assign isBranch             = slot_q.is_branch;
  assign isLoad               = slot_q.is_load;
  assign isStore              = slot_q.is_store;
  assign isAluImm             = slot_q.is_alu_imm;
  assign isAluReg             = slot_q.is_alu_reg;
  assign isSystem             = slot_q.is_system;

endmodule

// File: tb/tb_pipe_decode.sv
// Scoreboard bench for pipe_decode: stimulus pushes hand-computed expectations, a monitor compares after each edge.
module tb_pipe_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stepPipe = 1'b0;
  logic        pipeStall = 1'b0;
  logic [31:0] instruction = 32'hFFFF_FFFF;
  logic [31:0] programCounter = 32'd0;
  logic        hazardStall, decodeValid, funct7Bit5, invalidInstruction;
  logic [31:0] decodeProgramCounter, immediate;
  logic [4:0]  rs1Address, rs2Address, rdAddress;
  logic [2:0]  funct3;
  logic        isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isAluImm, isAluReg, isSystem;

  pipe_decode dut (
    .clk(clk), .rst(rst), .stepPipe(stepPipe), .pipeStall(pipeStall),
    .instruction(instruction), .programCounter(programCounter),
    .hazardStall(hazardStall), .decodeValid(decodeValid),
    .decodeProgramCounter(decodeProgramCounter),
    .rs1Address(rs1Address), .rs2Address(rs2Address), .rdAddress(rdAddress),
    .immediate(immediate), .funct3(funct3), .funct7Bit5(funct7Bit5),
    .isLui(isLui), .isAuipc(isAuipc), .isJal(isJal), .isJalr(isJalr),
    .isBranch(isBranch), .isLoad(isLoad), .isStore(isStore),
    .isAluImm(isAluImm), .isAluReg(isAluReg), .isSystem(isSystem),
    .invalidInstruction(invalidInstruction)
  );

  always #5 clk = ~clk;

  // cls order: lui auipc jal jalr branch load store aluimm alureg system
  typedef struct packed {
    logic        valid;
    logic        invalid;
    logic [9:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] pc;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic hz;
  } exp_t;

  localparam logic [9:0] C_LUI = 10'b1000000000, C_AUIPC = 10'b0100000000, C_JAL = 10'b0010000000,
                         C_BR  = 10'b0000100000, C_LD    = 10'b0000010000, C_ST  = 10'b0000001000,
                         C_AI  = 10'b0000000100, C_AR    = 10'b0000000010, C_SYS = 10'b0000000001;
  localparam obs_t BUB = '0;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  function automatic obs_t dv(logic [9:0] cls, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [31:0] imm, logic [2:0] f3, logic f7, logic [31:0] pc);
    obs_t o;
    o = '{valid: 1'b1, invalid: 1'b0, cls: cls, rs1: rs1, rs2: rs2, rd: rd, imm: imm, f3: f3, f7: f7, pc: pc};
    return o;
  endfunction

  function automatic obs_t inv(logic [31:0] pc);
    obs_t o;
    o = '0;
    o.valid = 1'b1;
    o.invalid = 1'b1;
    o.pc = pc;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{valid: decodeValid, invalid: invalidInstruction,
          cls: {isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isAluImm, isAluReg, isSystem},
          rs1: rs1Address, rs2: rs2Address, rd: rdAddress, imm: immediate,
          f3: funct3, f7: funct7Bit5, pc: decodeProgramCounter};
    return o;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step(logic [31:0] ins, logic [31:0] pc, logic stall, obs_t o, logic hz);
    exp_t e;
    @(negedge clk);
    instruction = ins;
    programCounter = pc;
    pipeStall = stall;
    stepPipe = 1'b1;
    e.o = o;
    e.hz = hz;
    sbq.push_back(e);
  endtask

  task automatic idle(logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    pipeStall = 1'b0;
    stepPipe = 1'b0;
  endtask

  // Monitor: strobe/hazard sampled just before the edge, registered outputs just after it.
  initial begin
    obs_t last;
    exp_t e;
    logic st, hz;
    last = '0;
    forever begin
      @(negedge clk);
      #4;
      st = stepPipe;
      hz = hazardStall;
      @(posedge clk);
      #1;
      if (!rst) begin
        check_obs("reset_state", sample(), '0);
        last = '0;
      end else if (st) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_step: got output %h with no expectation", sample());
        end else begin
          e = sbq.pop_front();
          total++;
          if (hz !== e.hz) begin
            bad++;
            $display("FAIL hazard_stall pc=%h: got %b expected %b", e.o.pc, hz, e.hz);
          end
          check_obs("decode", sample(), e.o);
          last = e.o;
        end
      end else begin
        check_obs("hold", sample(), last);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    step(32'hFFB10093, 32'h100, 1'b0, dv(C_AI, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFB, 3'd0, 1'b1, 32'h100), 1'b0);
    step(32'h123451B7, 32'h104, 1'b0, dv(C_LUI, 5'd0, 5'd0, 5'd3, 32'h12345000, 3'd5, 1'b0, 32'h104), 1'b0);
    idle(32'h0000007F);
    step(32'h00032283, 32'h108, 1'b0, dv(C_LD, 5'd6, 5'd0, 5'd5, 32'd0, 3'd2, 1'b0, 32'h108), 1'b0);
`ifdef PIPE_DECODE_HAZARD_EN
    step(32'h001283B3, 32'h10C, 1'b0, BUB, 1'b1);
    step(32'h0000007F, 32'h110, 1'b1, dv(C_AR, 5'd5, 5'd1, 5'd7, 32'd0, 3'd0, 1'b0, 32'h10C), 1'b0);
`else
    step(32'h001283B3, 32'h10C, 1'b0, dv(C_AR, 5'd5, 5'd1, 5'd7, 32'd0, 3'd0, 1'b0, 32'h10C), 1'b0);
    step(32'h0000007F, 32'h110, 1'b1, BUB, 1'b0);
`endif
    step(32'hFFB10093, 32'h114, 1'b1, BUB, 1'b0);
    step(32'hFFFFFFFF, 32'h118, 1'b0, BUB, 1'b0);
    step(32'h0000007F, 32'h200, 1'b0, inv(32'h200), 1'b0);
    step(32'h00000010, 32'h204, 1'b0, inv(32'h204), 1'b0);
    step(32'h0020A423, 32'h300, 1'b0, dv(C_ST, 5'd1, 5'd2, 5'd0, 32'd8, 3'd2, 1'b0, 32'h300), 1'b0);
    step(32'hFE208EE3, 32'h304, 1'b0, dv(C_BR, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd0, 1'b1, 32'h304), 1'b0);
    step(32'h008000EF, 32'h308, 1'b0, dv(C_JAL, 5'd0, 5'd0, 5'd1, 32'd8, 3'd0, 1'b0, 32'h308), 1'b0);
    step(32'h00001217, 32'h30C, 1'b0, dv(C_AUIPC, 5'd0, 5'd0, 5'd4, 32'h1000, 3'd1, 1'b0, 32'h30C), 1'b0);
    step(32'h402081B3, 32'h310, 1'b0, dv(C_AR, 5'd1, 5'd2, 5'd3, 32'd0, 3'd0, 1'b1, 32'h310), 1'b0);
    step(32'h00000073, 32'h314, 1'b0, dv(C_SYS, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b0, 32'h314), 1'b0);
    idle(32'hFFB10093);
    idle(32'h123451B7);

    // Asynchronous reset while the add sits in the replay register.
    step(32'h00032283, 32'h400, 1'b0, dv(C_LD, 5'd6, 5'd0, 5'd5, 32'd0, 3'd2, 1'b0, 32'h400), 1'b0);
`ifdef PIPE_DECODE_HAZARD_EN
    step(32'h001283B3, 32'h404, 1'b0, BUB, 1'b1);
`else
    step(32'h001283B3, 32'h404, 1'b0, dv(C_AR, 5'd5, 5'd1, 5'd7, 32'd0, 3'd0, 1'b0, 32'h404), 1'b0);
`endif
    idle(32'hFFB10093);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_obs("async_reset", sample(), '0);
    total++;
    if (hazardStall !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_hazard: got %b expected 0", hazardStall);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(32'hFFB10093, 32'h500, 1'b0, dv(C_AI, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFB, 3'd0, 1'b1, 32'h500), 1'b0);
    step(32'h123451B7, 32'h504, 1'b0, dv(C_LUI, 5'd0, 5'd0, 5'd3, 32'h12345000, 3'd5, 1'b0, 32'h504), 1'b0);
    idle(32'hFFFFFFFF);
    repeat (3) @(negedge clk);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
